// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU / multiply-divide unit:
// main-decoder ALUOp codes, R-type funct codes, the internal control
// code the decoder produces, and the multiply/divide sequencer states.
package alu_pkg;

    // Main-decoder ALUOp encodings
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_XOR   = 3'b101;
    localparam logic [2:0] ALUOP_NOR   = 3'b110;
    localparam logic [2:0] ALUOP_SLT   = 3'b111;

    // R-type funct field encodings
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Internal operation selected by the decoder
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
        ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_ILLEGAL
    } alu_ctrl_t;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Map ALUOp/Funct onto the internal control code
    function automatic alu_ctrl_t alu_decode(input logic [2:0] aluop,
                                             input logic [5:0] funct);
        alu_ctrl_t ctrl;
        ctrl = ALU_ILLEGAL;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_AND: ctrl = ALU_AND;
            ALUOP_OR:  ctrl = ALU_OR;
            ALUOP_XOR: ctrl = ALU_XOR;
            ALUOP_NOR: ctrl = ALU_NOR;
            ALUOP_SLT: ctrl = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:   ctrl = ALU_ADD;
                    FN_SUB:   ctrl = ALU_SUB;
                    FN_AND:   ctrl = ALU_AND;
                    FN_OR:    ctrl = ALU_OR;
                    FN_XOR:   ctrl = ALU_XOR;
                    FN_NOR:   ctrl = ALU_NOR;
                    FN_SLT:   ctrl = ALU_SLT;
                    FN_SLL:   ctrl = ALU_SLL;
                    FN_SRL:   ctrl = ALU_SRL;
                    FN_SRA:   ctrl = ALU_SRA;
                    FN_MFHI:  ctrl = ALU_MFHI;
                    FN_MTHI:  ctrl = ALU_MTHI;
                    FN_MFLO:  ctrl = ALU_MFLO;
                    FN_MTLO:  ctrl = ALU_MTLO;
                    FN_MULT:  ctrl = ALU_MULT;
                    FN_MULTU: ctrl = ALU_MULTU;
                    FN_DIV:   ctrl = ALU_DIV;
                    FN_DIVU:  ctrl = ALU_DIVU;
                    default:  ctrl = ALU_ILLEGAL;
                endcase
            end
            default: ctrl = ALU_ILLEGAL;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_muldiv_unit_muldiv_iter.sv
// Iterative multiply/divide engine owning HI/LO.
// Operands are converted to magnitudes on accept, WIDTH shift-add or
// restoring shift-subtract steps run in RUN, and FIX applies the sign
// correction and commits HI/LO with a one-cycle o_done pulse.
// Handshake: i_start is only asserted by the parent when o_busy=0
// (state IDLE); o_busy stays high from the cycle after accept until the
// cycle o_done pulses.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    md_state_t          r_state;
    md_state_t          w_next_state;
    logic [SHW-1:0]     r_count;
    logic [2*WIDTH-1:0] r_prod;     // {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;    // product / quotient must be negated
    logic               r_neg_r;    // remainder takes the dividend's sign
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_step;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_a_neg = i_signed & i_a[WIDTH-1];
    assign w_b_neg = i_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // One shift-add step: add multiplicand into upper half when the
    // current multiplier LSB is set, then shift the whole register right.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_step = {w_mul_sum, r_prod[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits.
    assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
    assign w_div_step  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};

    assign w_quo = r_prod[WIDTH-1:0];
    assign w_rem = r_prod[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic: accept -> WIDTH steps -> fix-up -> idle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (r_count == LAST_STEP) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        o_busy  = (r_state != IDLE);
        o_state = r_state;
    end

    // Operand latch, iteration datapath, sign fix-up and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_count    <= '0;
                        r_is_div   <= i_div;
                        r_mcand    <= w_b_mag;
                        r_prod     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= i_div & (i_b == '0);
                    end else begin
                        if (i_mthi) r_hi <= i_a;
                        if (i_mtlo) r_lo <= i_a;
                    end
                end
                RUN: begin
                    r_count <= r_count + SHW'(1);
                    r_prod  <= r_is_div ? w_div_step : w_mul_step;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_lo <= r_div_zero ? '1 : (r_neg_q ? -w_quo : w_quo);
                        r_hi <= r_neg_r ? -w_rem : w_rem;
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? -r_prod : r_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_done = r_done;

endmodule

// File: rtl/alu_muldiv_unit.sv
// EX-stage execution unit: decodes ALUOp/Funct, computes single-cycle
// ALU/shift/mfhi/mflo results into a registered Result, and hands
// mult/div/mthi/mtlo to the iterative engine that owns HI/LO.
// Handshake: an op is accepted on an edge where Start=1 and Busy=0;
// Start while Busy=1 is dropped with no side effect.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [SHW-1:0]   Shamt,
    output logic [WIDTH-1:0] Result,
    output logic             ResultValid,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal,
    output logic [1:0]       o_dbg_state
);

    alu_ctrl_t        w_ctrl;
    logic             w_busy;
    logic             w_accept;
    logic             w_md_start;
    logic             w_md_signed;
    logic             w_md_div;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_slt;
    logic             w_has_result;
    logic [WIDTH-1:0] w_alu_out;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic             r_illegal;

    assign w_ctrl      = alu_decode(ALUOp, Funct);
    assign w_accept    = Start & ~w_busy;
    assign w_md_start  = w_accept & ((w_ctrl == ALU_MULT) | (w_ctrl == ALU_MULTU) |
                                     (w_ctrl == ALU_DIV)  | (w_ctrl == ALU_DIVU));
    assign w_md_signed = (w_ctrl == ALU_MULT) | (w_ctrl == ALU_DIV);
    assign w_md_div    = (w_ctrl == ALU_DIV)  | (w_ctrl == ALU_DIVU);
    assign w_mthi      = w_accept & (w_ctrl == ALU_MTHI);
    assign w_mtlo      = w_accept & (w_ctrl == ALU_MTLO);
    assign w_slt       = ($signed(SrcA) < $signed(SrcB));

    // Single-cycle datapath; w_has_result marks ops that write Result
    always_comb begin
        w_alu_out    = '0;
        w_has_result = 1'b1;
        case (w_ctrl)
            ALU_ADD:  w_alu_out = SrcA + SrcB;
            ALU_SUB:  w_alu_out = SrcA - SrcB;
            ALU_AND:  w_alu_out = SrcA & SrcB;
            ALU_OR:   w_alu_out = SrcA | SrcB;
            ALU_XOR:  w_alu_out = SrcA ^ SrcB;
            ALU_NOR:  w_alu_out = ~(SrcA | SrcB);
            ALU_SLT:  w_alu_out = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLL:  w_alu_out = SrcB << Shamt;
            ALU_SRL:  w_alu_out = SrcB >> Shamt;
            ALU_SRA:  w_alu_out = WIDTH'($signed(SrcB) >>> Shamt);
            ALU_MFHI: w_alu_out = w_hi;
            ALU_MFLO: w_alu_out = w_lo;
            default:  w_has_result = 1'b0;
        endcase
    end

    // Result register plus one-cycle ResultValid / Illegal pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            if (w_accept) begin
                if (w_has_result) begin
                    r_result       <= w_alu_out;
                    r_result_valid <= 1'b1;
                end
                if (w_ctrl == ALU_ILLEGAL) r_illegal <= 1'b1;
            end
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_md_start),
        .i_signed (w_md_signed),
        .i_div    (w_md_div),
        .i_a      (SrcA),
        .i_b      (SrcB),
        .i_mthi   (w_mthi),
        .i_mtlo   (w_mtlo),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_busy   (w_busy),
        .o_done   (Done),
        .o_state  (o_dbg_state)
    );

    assign Result      = r_result;
    assign ResultValid = r_result_valid;
    assign Busy        = w_busy;
    assign Illegal     = r_illegal;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit at WIDTH=32: directed vectors, a cycle
// model built from plain arithmetic, a per-cycle compare process, and
// literal expectations for the documented corner cases.
module tb_alu_muldiv_unit;
    import alu_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  ALUOp;
    logic [5:0]  Funct;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  Shamt;
    logic [31:0] Result;
    logic        ResultValid;
    logic        Busy;
    logic        Done;
    logic        Illegal;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .ALUOp       (ALUOp),
        .Funct       (Funct),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Shamt       (Shamt),
        .Result      (Result),
        .ResultValid (ResultValid),
        .Busy        (Busy),
        .Done        (Done),
        .Illegal     (Illegal),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Multi-cycle ops are modelled as "HI/LO become the arithmetic answer
    // 33 edges after accept, busy in between".
    logic        model_live = 1'b0;
    logic [31:0] m_result, m_hi, m_lo, p_hi, p_lo;
    logic        m_valid, m_done, m_illegal, m_busy;
    int          m_left;

    always @(posedge clk) begin
        logic [31:0] a, b;
        longint      pr;
        int          sa, sb;
        model_live = 1'b1;
        m_valid    = 1'b0;
        m_done     = 1'b0;
        m_illegal  = 1'b0;
        a  = SrcA;
        b  = SrcB;
        sa = int'(a);
        sb = int'(b);
        if (reset) begin
            m_result = '0; m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
        end else if (Start) begin
            if (ALUOp != ALUOP_FUNCT) begin
                m_valid = 1'b1;
                case (ALUOp)
                    ALUOP_ADD: m_result = a + b;
                    ALUOP_SUB: m_result = a - b;
                    ALUOP_AND: m_result = a & b;
                    ALUOP_OR:  m_result = a | b;
                    ALUOP_XOR: m_result = a ^ b;
                    ALUOP_NOR: m_result = ~(a | b);
                    default:   m_result = (sa < sb) ? 32'd1 : 32'd0;
                endcase
            end else begin
                case (Funct)
                    FN_ADD:  begin m_result = a + b;       m_valid = 1'b1; end
                    FN_SUB:  begin m_result = a - b;       m_valid = 1'b1; end
                    FN_AND:  begin m_result = a & b;       m_valid = 1'b1; end
                    FN_OR:   begin m_result = a | b;       m_valid = 1'b1; end
                    FN_XOR:  begin m_result = a ^ b;       m_valid = 1'b1; end
                    FN_NOR:  begin m_result = ~(a | b);    m_valid = 1'b1; end
                    FN_SLT:  begin m_result = (sa < sb) ? 32'd1 : 32'd0; m_valid = 1'b1; end
                    FN_SLL:  begin m_result = b << Shamt;  m_valid = 1'b1; end
                    FN_SRL:  begin m_result = b >> Shamt;  m_valid = 1'b1; end
                    FN_SRA:  begin m_result = sb >>> Shamt; m_valid = 1'b1; end
                    FN_MFHI: begin m_result = m_hi;        m_valid = 1'b1; end
                    FN_MFLO: begin m_result = m_lo;        m_valid = 1'b1; end
                    FN_MTHI: m_hi = a;
                    FN_MTLO: m_lo = a;
                    FN_MULT: begin
                        pr = longint'(sa) * longint'(sb);
                        {p_hi, p_lo} = pr;
                        m_left = 33;
                    end
                    FN_MULTU: begin
                        pr = longint'({32'b0, a}) * longint'({32'b0, b});
                        {p_hi, p_lo} = pr;
                        m_left = 33;
                    end
                    FN_DIV: begin
                        if (b == 0) begin p_lo = '1; p_hi = a; end
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            p_lo = a; p_hi = '0;
                        end else begin
                            p_lo = sa / sb; p_hi = sa % sb;
                        end
                        m_left = 33;
                    end
                    FN_DIVU: begin
                        if (b == 0) begin p_lo = '1; p_hi = a; end
                        else begin p_lo = a / b; p_hi = a % b; end
                        m_left = 33;
                    end
                    default: m_illegal = 1'b1;
                endcase
            end
        end
        m_busy = (m_left != 0);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("result",  Result, m_result);
            chk("valid",   32'(ResultValid), 32'(m_valid));
            chk("busy",    32'(Busy),        32'(m_busy));
            chk("done",    32'(Done),        32'(m_done));
            chk("illegal", 32'(Illegal),     32'(m_illegal));
            if (!m_busy) chk("fsm_idle", 32'(dbg_state), 32'(IDLE));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        ALUOp = op; Funct = fn; SrcA = a; SrcB = b; Shamt = sh; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic rd_hi(output logic [31:0] v);
        issue(ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0, 5'd0);
        v = Result;
    endtask

    task automatic rd_lo(output logic [31:0] v);
        issue(ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0, 5'd0);
        v = Result;
    endtask

    // Wait for Done with a bound; optionally returns Busy-high cycle count
    task automatic wait_done(output int busy_cycles);
        int seen;
        seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (Done) begin seen = 1; break; end
            if (Busy) busy_cycles++;
            @(posedge clk); #1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_md(input string name, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bc;
        logic [31:0] v;
        issue(ALUOP_FUNCT, fn, a, b, 5'd0);
        wait_done(bc);
        chk({name, "_busy_cycles"}, 32'(bc), 32'd33);
        rd_hi(v); chk({name, "_hi"}, v, exp_hi);
        rd_lo(v); chk({name, "_lo"}, v, exp_lo);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        int bc;
        reset = 1'b1; Start = 1'b0; ALUOp = '0; Funct = '0;
        SrcA = '0; SrcB = '0; Shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", Result, 32'd0);
        chk("reset_busy",   32'(Busy), 32'd0);
        reset = 1'b0;

        // single-cycle ops
        issue(ALUOP_FUNCT, FN_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("add_wrap", Result, 32'h8000_0000);
        chk("add_valid", 32'(ResultValid), 32'd1);
        issue(ALUOP_FUNCT, FN_SRA, 32'd0, 32'h8000_0000, 5'd4);
        chk("sra", Result, 32'hF800_0000);
        issue(ALUOP_FUNCT, FN_SRL, 32'd0, 32'h8000_0000, 5'd4);
        chk("srl", Result, 32'h0800_0000);
        issue(ALUOP_FUNCT, FN_SLL, 32'd0, 32'd1, 5'd31);
        chk("sll", Result, 32'h8000_0000);
        issue(ALUOP_SUB, 6'd0, 32'd5, 32'd7, 5'd0);
        chk("sub", Result, 32'hFFFF_FFFE);
        issue(ALUOP_SLT, 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt_signed", Result, 32'd1);
        issue(ALUOP_FUNCT, FN_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0);
        chk("slt_false", Result, 32'd0);
        issue(ALUOP_NOR, 6'd0, 32'h0000_FFFF, 32'h00FF_0000, 5'd0);
        chk("nor", Result, 32'hFF00_0000);
        issue(ALUOP_XOR, 6'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        chk("xor", Result, 32'h0FF0_0FF0);
        issue(ALUOP_AND, 6'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        chk("and", Result, 32'hF000_F000);
        issue(ALUOP_OR, 6'd0, 32'hF0F0_F0F0, 32'h0F00_0000, 5'd0);
        chk("or", Result, 32'hFFF0_F0F0);

        // multiply / divide
        run_md("mult",  FN_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu", FN_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
        run_md("div",   FN_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", FN_DIVU,  32'd7,         32'd0, 32'd7,         32'hFFFF_FFFF);
        run_md("divu",  FN_DIVU,  32'd100,       32'd7, 32'd2,         32'd14);
        run_md("div0s", FN_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // overflow divide with Start pulses while busy
        issue(ALUOP_FUNCT, FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue(ALUOP_FUNCT, FN_ADD, 32'd1, 32'd1, 5'd0);
        chk("busy_ignored_add", 32'(ResultValid), 32'd0);
        issue(ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0, 5'd0);
        issue(ALUOP_FUNCT, FN_MULT, 32'd3, 32'd3, 5'd0);
        issue(ALUOP_FUNCT, FN_MTLO, 32'hDEAD_BEEF, 32'd0, 5'd0);
        wait_done(bc);
        rd_hi(v); chk("divovf_hi", v, 32'd0);
        rd_lo(v); chk("divovf_lo", v, 32'h8000_0000);
        chk("no_extra_done", 32'(Done), 32'd0);

        // reset in the middle of a multiply
        issue(ALUOP_FUNCT, FN_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        issue(ALUOP_FUNCT, FN_ADD, 32'd2, 32'd3, 5'd0);
        chk("post_reset_add", Result, 32'd5);
        rd_hi(v); chk("abort_hi", v, 32'd0);
        rd_lo(v); chk("abort_lo", v, 32'd0);

        // a full multiply checked only through the model
        issue(ALUOP_FUNCT, FN_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        wait_done(bc);
        rd_hi(v);
        rd_lo(v);

        // illegal funct, mthi/mtlo
        issue(ALUOP_FUNCT, FN_ADD, 32'h11, 32'h22, 5'd0);
        issue(ALUOP_FUNCT, 6'b001111, 32'hAAAA, 32'hBBBB, 5'd0);
        chk("illegal_pulse", 32'(Illegal), 32'd1);
        chk("illegal_novalid", 32'(ResultValid), 32'd0);
        chk("illegal_result", Result, 32'h33);
        issue(ALUOP_FUNCT, FN_MTHI, 32'h1234, 32'd0, 5'd0);
        chk("mthi_novalid", 32'(ResultValid), 32'd0);
        chk("illegal_once", 32'(Illegal), 32'd0);
        rd_hi(v); chk("mthi_mfhi", v, 32'h1234);
        issue(ALUOP_FUNCT, FN_MTLO, 32'hABCD, 32'd0, 5'd0);
        rd_lo(v); chk("mtlo_mflo", v, 32'hABCD);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
